sudoku_check_dp: RTL and testbench



---
 rtl/sudoku_check_dp_if.sv | 26 ++
 rtl/sudoku_check_dp.sv | 185 ++++++++++++++++++
 tb/tb_sudoku_check_dp.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sudoku_check_dp_if.sv
// Board-read and check-request bus between the game controller and sudoku_check_dp.
// master = checker datapath side, slave = controller/board-memory side.
interface sudoku_check_dp_if #(
    parameter int VAL_W  = 4,
    parameter int ADDR_W = 7
) ();
    logic              check_flag;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [VAL_W-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic              solved;
    logic [1:0]        err_type;
    logic [3:0]        err_idx;

    modport master (
        input  check_flag, rd_data,
        output rd_en, rd_addr, busy, done, solved, err_type, err_idx
    );

    modport slave (
        output check_flag, rd_data,
        input  rd_en, rd_addr, busy, done, solved, err_type, err_idx
    );
endinterface

// File: rtl/sudoku_check_dp.sv
// Sudoku board checker: sweeps rows, columns and boxes (243 reads) and reports a held verdict.
// Optional macro CHK_EARLY_EXIT_EN stops issuing reads at the first failing cell.
module sudoku_check_dp #(
    parameter int VAL_W  = 4,
    parameter int ADDR_W = 7
) (
    input logic              clka,
    input logic              restart,
    sudoku_check_dp_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam logic [1:0] GT_ROW   = 2'd0;
    localparam logic [1:0] GT_COL   = 2'd1;
    localparam logic [1:0] GT_BOX   = 2'd2;
    localparam logic [1:0] ERR_NONE = 2'd3;

    // Constant tables replace x/3 and x%3 for the box address mapping.
    function automatic logic [3:0] div3(input logic [3:0] x);
        case (x)
            4'd0, 4'd1, 4'd2: div3 = 4'd0;
            4'd3, 4'd4, 4'd5: div3 = 4'd1;
            default:          div3 = 4'd2;
        endcase
    endfunction

    function automatic logic [3:0] mod3(input logic [3:0] x);
        case (x)
            4'd0, 4'd3, 4'd6: mod3 = 4'd0;
            4'd1, 4'd4, 4'd7: mod3 = 4'd1;
            default:          mod3 = 4'd2;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        flag_q;
    logic [1:0]  gtype_q, gtype_d;
    logic [3:0]  gidx_q, gidx_d, eidx_q, eidx_d;
    logic        vld_p1_q;
    logic [1:0]  gtype_p1_q;
    logic [3:0]  gidx_p1_q, eidx_p1_q;
    logic [8:0]  seen_q, seen_d;
    logic        fail_q, fail_d;
    logic [1:0]  capt_type_q, capt_type_d;
    logic [3:0]  capt_idx_q, capt_idx_d;
    logic        solved_q, solved_d;
    logic [1:0]  err_type_q, err_type_d;
    logic [3:0]  err_idx_q, err_idx_d;

    logic              start, last_issue, beat_bad;
    logic [3:0]        row, col, box_base;
    logic [ADDR_W-1:0] cell_addr;
    logic [8:0]        onehot, seen_base;

    assign start      = bus.check_flag && !flag_q && (state_q == IDLE);
    assign last_issue = (gtype_q == GT_BOX) && (gidx_q == 4'd8) && (eidx_q == 4'd8);

    // Stage p0: address generation from the sweep counters.
    always_comb begin
        row      = 4'd0;
        col      = 4'd0;
        box_base = div3(gidx_q);
        case (gtype_q)
            GT_ROW: begin row = gidx_q; col = eidx_q; end
            GT_COL: begin row = eidx_q; col = gidx_q; end
            default: begin
                row = (box_base << 1) + box_base + div3(eidx_q);
                col = (mod3(gidx_q) << 1) + mod3(gidx_q) + mod3(eidx_q);
            end
        endcase
        cell_addr = ADDR_W'({row, 3'b000}) + ADDR_W'(row) + ADDR_W'(col);
    end

    assign bus.rd_en    = (state_q == ISSUE);
    assign bus.rd_addr  = (state_q == ISSUE) ? cell_addr : '0;
    assign bus.busy     = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done     = (state_q == FINISH);
    assign bus.solved   = solved_q;
    assign bus.err_type = err_type_q;
    assign bus.err_idx  = err_idx_q;

    // Stage p1: returning cell checked against its tagged group's seen mask.
    always_comb begin
        onehot = 9'd0;
        if (bus.rd_data != '0 && bus.rd_data <= VAL_W'(9))
            onehot = 9'b1 << (bus.rd_data - VAL_W'(1));
        seen_base = (eidx_p1_q == 4'd0) ? 9'd0 : seen_q;
        beat_bad  = vld_p1_q && ((onehot == 9'd0) || ((seen_base & onehot) != 9'd0));
        seen_d    = vld_p1_q ? (seen_base | onehot) : seen_q;

        fail_d      = fail_q;
        capt_type_d = capt_type_q;
        capt_idx_d  = capt_idx_q;
        if (start) begin
            fail_d = 1'b0;
        end else if (beat_bad && !fail_q) begin
            fail_d      = 1'b1;
            capt_type_d = gtype_p1_q;
            capt_idx_d  = gidx_p1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        gtype_d    = gtype_q;
        gidx_d     = gidx_q;
        eidx_d     = eidx_q;
        solved_d   = solved_q;
        err_type_d = err_type_q;
        err_idx_d  = err_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ISSUE;
                    gtype_d    = GT_ROW;
                    gidx_d     = 4'd0;
                    eidx_d     = 4'd0;
                    solved_d   = 1'b0;
                    err_type_d = ERR_NONE;
                    err_idx_d  = 4'd0;
                end
            end
            ISSUE: begin
                if (eidx_q == 4'd8) begin
                    eidx_d = 4'd0;
                    if (gidx_q == 4'd8) begin
                        gidx_d  = 4'd0;
                        gtype_d = gtype_q + 2'd1;
                    end else begin
                        gidx_d = gidx_q + 4'd1;
                    end
                end else begin
                    eidx_d = eidx_q + 4'd1;
                end
                if (last_issue) state_d = DRAIN;
`ifdef CHK_EARLY_EXIT_EN
                if (beat_bad) state_d = DRAIN;
`endif
            end
            DRAIN: begin
                // Verdict includes the beat arriving this cycle so it is valid alongside done.
                state_d    = FINISH;
                solved_d   = !fail_d;
                err_type_d = fail_d ? capt_type_d : ERR_NONE;
                err_idx_d  = fail_d ? capt_idx_d : 4'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q    <= IDLE;
            flag_q     <= 1'b0;
            gtype_q    <= GT_ROW;
            gidx_q     <= 4'd0;
            eidx_q     <= 4'd0;
            vld_p1_q   <= 1'b0;
            fail_q     <= 1'b0;
            solved_q   <= 1'b0;
            err_type_q <= ERR_NONE;
            err_idx_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            flag_q     <= bus.check_flag;
            gtype_q    <= gtype_d;
            gidx_q     <= gidx_d;
            eidx_q     <= eidx_d;
            vld_p1_q   <= (state_q == ISSUE);
            fail_q     <= fail_d;
            solved_q   <= solved_d;
            err_type_q <= err_type_d;
            err_idx_q  <= err_idx_d;
        end
    end

    always_ff @(posedge clka) begin
        gtype_p1_q  <= gtype_q;
        gidx_p1_q   <= gidx_q;
        eidx_p1_q   <= eidx_q;
        seen_q      <= seen_d;
        capt_type_q <= capt_type_d;
        capt_idx_q  <= capt_idx_d;
    end
endmodule

// File: tb/tb_sudoku_check_dp.sv
// Directed bench for sudoku_check_dp: board memory model plus hand-derived verdicts and latencies.
module tb_sudoku_check_dp;
    logic clka = 1'b0;
    logic restart;
    always #5 clka = ~clka;

    sudoku_check_dp_if #(.VAL_W(4), .ADDR_W(7)) io ();
    sudoku_check_dp #(.VAL_W(4), .ADDR_W(7)) dut (
        .clka    (clka),
        .restart (restart),
        .bus     (io)
    );

    logic [3:0] mem [0:80];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Synchronous read port; returns 0 when idle so stray data would look like an empty cell.
    always @(posedge clka) io.rd_data <= io.rd_en ? mem[io.rd_addr] : 4'd0;

`ifdef CHK_EARLY_EXIT_EN
    localparam int DONE44 = 44, RD44 = 42, DONESW = 88, RDSW = 86, DONE80 = 84, RD80 = 82;
`else
    localparam int DONE44 = 245, RD44 = 243, DONESW = 245, RDSW = 243, DONE80 = 245, RD80 = 243;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_valid();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                mem[r*9+c] = 4'((r*3 + r/3 + c) % 9 + 1);
    endtask

    function automatic logic [6:0] exp_addr(input int i);
        int gt, gi, e, r, c;
        gt = i / 81; gi = (i / 9) % 9; e = i % 9;
        if (gt == 0)      begin r = gi; c = e; end
        else if (gt == 1) begin r = e;  c = gi; end
        else begin r = 3*(gi/3) + e/3; c = 3*(gi%3) + e%3; end
        return 7'(r*9 + c);
    endfunction

    task automatic run_scan(input string tag, input int exp_done, input logic exp_solved,
                            input logic [1:0] exp_type, input logic [3:0] exp_idx, input int exp_rd);
        int done_cyc, rd_cnt, first_rd, last_rd, addr_err;
        logic busy1, solved1;
        done_cyc = -1; rd_cnt = 0; first_rd = -1; last_rd = -1; addr_err = 0;
        busy1 = 1'b0; solved1 = 1'b1;
        @(negedge clka); io.check_flag = 1'b1;
        @(posedge clka);
        for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
            @(negedge clka);
            if (k == 1) begin busy1 = io.busy; solved1 = io.solved; end
            if (io.rd_en) begin
                if (first_rd < 0) first_rd = k;
                last_rd = k;
                if (io.rd_addr !== exp_addr(rd_cnt)) addr_err++;
                rd_cnt++;
            end
            if (io.done) done_cyc = k;
        end
        check({tag, "_busy_start"}, busy1, 1);
        check({tag, "_solved_cleared"}, solved1, 0);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_busy_at_done"}, io.busy, 0);
        check({tag, "_solved"}, io.solved, exp_solved);
        check({tag, "_err_type"}, io.err_type, exp_type);
        check({tag, "_err_idx"}, io.err_idx, exp_idx);
        check({tag, "_rd_count"}, rd_cnt, exp_rd);
        check({tag, "_rd_first"}, first_rd, 1);
        check({tag, "_rd_last"}, last_rd, exp_rd);
        check({tag, "_addr_seq_errors"}, addr_err, 0);
        io.check_flag = 1'b0;
    endtask

    initial begin
        int dones, done_at;
        restart = 1'b1;
        io.check_flag = 1'b0;
        load_valid();
        repeat (3) @(posedge clka);
        @(negedge clka);
        check("rst_rd_en", io.rd_en, 0);
        check("rst_rd_addr", io.rd_addr, 0);
        check("rst_busy", io.busy, 0);
        check("rst_done", io.done, 0);
        check("rst_solved", io.solved, 0);
        check("rst_err_type", io.err_type, 3);
        check("rst_err_idx", io.err_idx, 0);
        restart = 1'b0;

        run_scan("valid", 245, 1'b1, 2'd3, 4'd0, 243);

        // Abort at N+100 with a reset.
        @(negedge clka); io.check_flag = 1'b1;
        @(posedge clka);
        for (int k = 1; k <= 100; k++) @(negedge clka);
        check("pre_abort_busy", io.busy, 1);
        restart = 1'b1; io.check_flag = 1'b0;
        @(negedge clka);
        check("abort_busy", io.busy, 0);
        check("abort_rd_en", io.rd_en, 0);
        check("abort_solved", io.solved, 0);
        check("abort_err_type", io.err_type, 3);
        restart = 1'b0;
        dones = 0;
        for (int k = 0; k < 300; k++) begin @(negedge clka); if (io.done) dones++; end
        check("abort_no_done", dones, 0);
        run_scan("after_abort", 245, 1'b1, 2'd3, 4'd0, 243);

        load_valid(); mem[40] = 4'd0;
        run_scan("cell44_empty", DONE44, 1'b0, 2'd0, 4'd4, RD44);

        load_valid(); mem[0] = 4'd2; mem[1] = 4'd1;
        run_scan("col_swap", DONESW, 1'b0, 2'd1, 4'd0, RDSW);

        load_valid(); mem[80] = 4'd12;
        run_scan("addr80_illegal", DONE80, 1'b0, 2'd0, 4'd8, RD80);

        // Flag held high; a low/high blip while busy must not retrigger.
        load_valid();
        dones = 0; done_at = -1;
        @(negedge clka); io.check_flag = 1'b1;
        @(posedge clka);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clka);
            if (k == 50) io.check_flag = 1'b0;
            if (k == 60) io.check_flag = 1'b1;
            if (io.done) begin dones++; if (done_at < 0) done_at = k; end
        end
        check("held_done_count", dones, 1);
        check("held_done_cycle", done_at, 245);
        check("held_solved", io.solved, 1);
        io.check_flag = 1'b0;
        run_scan("reedge", 245, 1'b1, 2'd3, 4'd0, 243);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
